// File: rtl/cpu_controller_pkg.sv
// -----------------------------------------------------------------------------
// cpu_controller_pkg
// Shared definitions for the 8-bit accumulator CPU sequencer:
//   - opcode encodings (same values the ALU decodes)
//   - phase encoding of the eight-phase fetch/execute cycle
//   - datapath strobe bundle produced by the controller decode
//   - is_aluop() helper: opcodes that read an operand and load the accumulator
// Optional feature macro used by the importing files: CPU_CTRL_STEP_EN
// -----------------------------------------------------------------------------
package cpu_controller_pkg;

   localparam logic [2:0] OPCODE_HLT = 3'b000;
   localparam logic [2:0] OPCODE_SKZ = 3'b001;
   localparam logic [2:0] OPCODE_ADD = 3'b010;
   localparam logic [2:0] OPCODE_AND = 3'b011;
   localparam logic [2:0] OPCODE_XOR = 3'b100;
   localparam logic [2:0] OPCODE_LDA = 3'b101;
   localparam logic [2:0] OPCODE_STO = 3'b110;
   localparam logic [2:0] OPCODE_JMP = 3'b111;

   // Encoded in cycle order so the counter advances with a plain +1 and
   // wraps from STORE back to INST_ADDR.
   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic wr;
      logic data_e;
   } strobes_t;

   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OPCODE_ADD) || (op == OPCODE_AND) ||
             (op == OPCODE_XOR) || (op == OPCODE_LDA);
   endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// -----------------------------------------------------------------------------
// cpu_phase_counter
// Owns the phase register, the sticky HALTED flag and (optionally) the WAIT
// state used for single-stepping.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   halt_req_i  in   HLT decoded in OP_ADDR; enter HALTED on this edge
//   step_i      in   single-step advance (only with CPU_CTRL_STEP_EN)
//   phase_o     out  current phase
//   halted_o    out  HALTED flag
//   wait_o      out  WAIT state active (always 0 without CPU_CTRL_STEP_EN)
// Macro: CPU_CTRL_STEP_EN adds the step input and the WAIT state after STORE.
// -----------------------------------------------------------------------------
module cpu_phase_counter
   import cpu_controller_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   halt_req_i,
`ifdef CPU_CTRL_STEP_EN
   input  logic   step_i,
`endif
   output phase_e phase_o,
   output logic   halted_o,
   output logic   wait_o
);

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;

`ifdef CPU_CTRL_STEP_EN
   logic   wait_q, wait_d;
`endif

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
`ifdef CPU_CTRL_STEP_EN
      wait_d   = wait_q;
`endif
      // HALTED freezes everything; only reset leaves it.
      if (!halted_q) begin
         if (halt_req_i) begin
            halted_d = 1'b1;
`ifdef CPU_CTRL_STEP_EN
         end else if (wait_q) begin
            // phase_q already holds INST_ADDR; releasing WAIT resumes there.
            if (step_i) wait_d = 1'b0;
`endif
         end else if (phase_q == PH_STORE) begin
            phase_d = PH_INST_ADDR;
`ifdef CPU_CTRL_STEP_EN
            wait_d  = 1'b1;
`endif
         end else begin
            phase_d = phase_e'(phase_q + 3'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
`ifdef CPU_CTRL_STEP_EN
         wait_q   <= 1'b0;
`endif
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
`ifdef CPU_CTRL_STEP_EN
         wait_q   <= wait_d;
`endif
      end
   end

   assign phase_o  = phase_q;
   assign halted_o = halted_q;
`ifdef CPU_CTRL_STEP_EN
   assign wait_o   = wait_q;
`else
   assign wait_o   = 1'b0;
`endif

endmodule

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Instruction sequencer for the 8-bit accumulator CPU. Decodes the registered
// phase, HALTED/WAIT state and the IR opcode into the datapath strobes, and
// counts retired instructions.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   opcode     in   IR opcode, valid from IDLE onward
//   zero       in   accumulator-zero flag, used only in ALU_OP
//   step       in   single-step pulse (only with CPU_CTRL_STEP_EN)
//   sel        out  address mux: 1 = PC, 0 = IR operand
//   rd         out  memory read enable
//   ld_ir      out  load instruction register
//   inc_pc     out  increment PC
//   ld_pc      out  load PC from IR operand
//   ld_ac      out  load accumulator
//   wr         out  memory write strobe
//   data_e     out  drive accumulator onto data bus
//   halt       out  processor halted (sticky)
//   instr_cnt  out  retired-instruction counter, wraps 255 -> 0
// Macro: CPU_CTRL_STEP_EN enables the step port and WAIT phase.
// -----------------------------------------------------------------------------
module cpu_controller
   import cpu_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef CPU_CTRL_STEP_EN
   input  logic       step,
`endif
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [7:0] instr_cnt
);

   phase_e   phase;
   logic     halted;
   logic     waiting;
   logic     halt_req;
   logic     active;
   strobes_t strb;
   logic [7:0] cnt_q, cnt_d;

   assign halt_req = (phase == PH_OP_ADDR) && (opcode == OPCODE_HLT);

   cpu_phase_counter u_phase (
      .clk        (clk),
      .rst_n      (rst_n),
      .halt_req_i (halt_req),
`ifdef CPU_CTRL_STEP_EN
      .step_i     (step),
`endif
      .phase_o    (phase),
      .halted_o   (halted),
      .wait_o     (waiting)
   );

   always_comb begin
      strb = '0;
      unique case (phase)
         PH_INST_ADDR:  strb.sel = 1'b1;
         PH_INST_FETCH: begin
            strb.sel = 1'b1;
            strb.rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            strb.sel   = 1'b1;
            strb.rd    = 1'b1;
            strb.ld_ir = 1'b1;
         end
         PH_OP_ADDR:    strb.inc_pc = 1'b1;
         PH_OP_FETCH:   strb.rd = is_aluop(opcode);
         PH_ALU_OP: begin
            strb.rd     = is_aluop(opcode);
            strb.inc_pc = (opcode == OPCODE_SKZ) && zero;
            strb.ld_pc  = (opcode == OPCODE_JMP);
            strb.data_e = (opcode == OPCODE_STO);
         end
         PH_STORE: begin
            strb.rd     = is_aluop(opcode);
            strb.ld_ac  = is_aluop(opcode);
            strb.ld_pc  = (opcode == OPCODE_JMP);
            strb.wr     = (opcode == OPCODE_STO);
            strb.data_e = (opcode == OPCODE_STO);
         end
         default: strb = '0;
      endcase
   end

   // Strobes are killed combinationally while reset is low so that an
   // aborted instruction never issues wr/ld_ac in the reset cycle.
   assign active = rst_n && !halted && !waiting;

   assign sel    = active && strb.sel;
   assign rd     = active && strb.rd;
   assign ld_ir  = active && strb.ld_ir;
   assign inc_pc = active && strb.inc_pc;
   assign ld_pc  = active && strb.ld_pc;
   assign ld_ac  = active && strb.ld_ac;
   assign wr     = active && strb.wr;
   assign data_e = active && strb.data_e;
   assign halt   = rst_n && (halted || (halt_req && !waiting));

   // Retire on leaving STORE; HLT never reaches STORE so it never counts.
   always_comb begin
      cnt_d = cnt_q;
      if (phase == PH_STORE && !halted) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

   assign instr_cnt = rst_n ? cnt_q : 8'd0;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

   localparam logic [2:0] OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010,
                          OP_AND = 3'b011, OP_XOR = 3'b100, OP_LDA = 3'b101,
                          OP_STO = 3'b110, OP_JMP = 3'b111;

   // Strobe bit positions in the compared vector
   localparam logic [8:0] SEL = 9'h100, RD = 9'h080, LDIR = 9'h040, INC = 9'h020,
                          LDPC = 9'h010, LDAC = 9'h008, WR = 9'h004, DE = 9'h002,
                          HLT = 9'h001, NONE = 9'h000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = OP_ADD;
   logic       zero = 1'b0;
   logic       step = 1'b0;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [7:0] instr_cnt;

   always #5 clk = ~clk;

   cpu_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .zero      (zero),
`ifdef CPU_CTRL_STEP_EN
      .step      (step),
`endif
      .sel       (sel),
      .rd        (rd),
      .ld_ir     (ld_ir),
      .inc_pc    (inc_pc),
      .ld_pc     (ld_pc),
      .ld_ac     (ld_ac),
      .wr        (wr),
      .data_e    (data_e),
      .halt      (halt),
      .instr_cnt (instr_cnt)
   );

   typedef struct {
      logic [8:0] s;
      logic [7:0] c;
      string      nm;
   } exp_t;

   typedef struct {
      logic [2:0]       op;
      logic             z;
      logic [3:0][8:0]  e;   // e[0]=OP_ADDR .. e[3]=STORE
      string            nm;
   } vec_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [8:0] act;

   assign act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

   // Monitor: compares the oldest pending expectation mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++;
         if (act !== e.s) begin
            bad++;
            $display("FAIL %s strobes got=%b want=%b", e.nm, act, e.s);
         end
         total++;
         if (instr_cnt !== e.c) begin
            bad++;
            $display("FAIL %s instr_cnt got=%0d want=%0d", e.nm, instr_cnt, e.c);
         end
      end
   end

   // One clock of stimulus; expectation queued for the monitor
   task automatic cyc(input logic r, input logic [2:0] op, input logic z,
                      input logic st, input logic [8:0] s, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n  = r;
      opcode = op;
      zero   = z;
      step   = st;
      e.s  = r ? s : NONE;
      e.c  = r ? exp_cnt : 8'd0;
      e.nm = nm;
      sb.push_back(e);
      if (!r) exp_cnt = 8'd0;
   endtask

   // Full instruction. Opcode before IDLE and zero outside ALU_OP are driven
   // to wrong values; step is held high outside WAIT.
   task automatic run_instr(input logic [2:0] op, input logic z,
                            input logic [3:0][8:0] e, input int abort_at,
                            input int hold, input string nm);
      logic [8:0] ex;
      logic [2:0] o;
      logic       zz;
      for (int p = 0; p < 8; p++) begin
         case (p)
            0:       ex = SEL;
            1:       ex = SEL | RD;
            2, 3:    ex = SEL | RD | LDIR;
            default: ex = e[p-4];
         endcase
         o  = (p < 3) ? ~op : op;
         zz = (p == 6) ? z : ~z;
         if (p == abort_at) begin
            cyc(1'b0, o, zz, 1'b1, NONE, $sformatf("%s/abort%0d", nm, p));
            return;
         end
         cyc(1'b1, o, zz, 1'b1, ex, $sformatf("%s/p%0d", nm, p));
      end
      exp_cnt = exp_cnt + 8'd1;
`ifdef CPU_CTRL_STEP_EN
      for (int h = 0; h < hold; h++)
         cyc(1'b1, op, ~z, 1'b0, NONE, $sformatf("%s/wait%0d", nm, h));
      cyc(1'b1, op, ~z, 1'b1, NONE, $sformatf("%s/step", nm));
`else
      if (hold < 0) $display("hold=%0d", hold);
`endif
   endtask

   vec_t tbl[10];
   logic [3:0][8:0] e_add;

   initial begin
      #5_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      e_add = {RD | LDAC, RD, RD, INC};
      tbl[0] = '{OP_ADD, 1'b0, e_add, "add"};
      tbl[1] = '{OP_AND, 1'b0, e_add, "and"};
      tbl[2] = '{OP_XOR, 1'b1, e_add, "xor"};
      tbl[3] = '{OP_LDA, 1'b0, e_add, "lda"};
      tbl[4] = '{OP_STO, 1'b0, {WR | DE, DE, NONE, INC}, "sto"};
      tbl[5] = '{OP_SKZ, 1'b1, {NONE, INC, NONE, INC}, "skz_z1"};
      tbl[6] = '{OP_SKZ, 1'b0, {NONE, NONE, NONE, INC}, "skz_z0"};
      tbl[7] = '{OP_JMP, 1'b0, {LDPC, LDPC, NONE, INC}, "jmp"};
      tbl[8] = '{OP_JMP, 1'b1, {LDPC, LDPC, NONE, INC}, "jmp_z1"};
      tbl[9] = '{OP_STO, 1'b1, {WR | DE, DE, NONE, INC}, "sto_z1"};

      // Reset held two cycles: everything 0
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, NONE, "rst0");
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, NONE, "rst1");

      // Table of instructions, first one also checks post-reset sel / sel+rd
      for (int i = 0; i < 10; i++)
         run_instr(tbl[i].op, tbl[i].z, tbl[i].e, -1, (i == 0) ? 10 : 0, tbl[i].nm);

      // Reset mid-instruction in STORE: no ld_ac, counter cleared
      run_instr(OP_ADD, 1'b0, e_add, 7, 0, "abort_store");
      run_instr(OP_STO, 1'b0, {WR | DE, DE, NONE, INC}, 7, 0, "abort_sto");
      run_instr(OP_ADD, 1'b0, e_add, -1, 0, "after_abort");

      // HLT: halt from OP_ADDR, then frozen with all strobes 0
      for (int p = 0; p < 4; p++)
         cyc(1'b1, (p == 3) ? OP_HLT : OP_ADD, 1'b1, 1'b0,
             (p == 0) ? SEL : (p == 1) ? (SEL | RD) : (SEL | RD | LDIR),
             $sformatf("hlt/p%0d", p));
      cyc(1'b1, OP_HLT, 1'b1, 1'b0, INC | HLT, "hlt/op_addr");
      for (int h = 0; h < 20; h++)
         cyc(1'b1, (h < 10) ? OP_HLT : OP_ADD, h[0], 1'b1, HLT,
             $sformatf("halted%0d", h));
      cyc(1'b0, OP_ADD, 1'b0, 1'b0, NONE, "hlt_rst");
      run_instr(OP_ADD, 1'b0, e_add, -1, 0, "post_hlt");

      // Counter wrap: retire until 255, then one more gives 0
      while (exp_cnt != 8'd255)
         run_instr(OP_LDA, 1'b0, e_add, -1, 0, "fill");
      run_instr(OP_ADD, 1'b0, e_add, -1, 0, "wrap");
      run_instr(OP_ADD, 1'b0, e_add, -1, 0, "post_wrap");

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction sequencer for the 8-bit accumulator CPU. It drives the fixed eight-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register. From that it issues every datapath strobe: address mux select, memory read/write, IR/AC/PC loads, PC increment, and data-bus enable. The ALU's `is_zero` gives conditional skip. It sits between the instruction register, the ALU/accumulator, the program counter and memory, and owns no data path itself.

## Interface
- No parameters; opcode encodings and phase encodings come from the shared package.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  3  current IR opcode; valid from phase IDLE onward.
- `zero`  in  1  accumulator-zero flag (ALU `is_zero`); sampled only in ALU_OP.
- `step`  in  1  single-step advance pulse; present only with `CPU_CTRL_STEP_EN`.
- `sel`  out  1  address mux: 1 = PC, 0 = IR operand field.
- `rd`  out  1  memory read enable.
- `ld_ir`  out  1  load instruction register.
- `inc_pc`  out  1  increment program counter.
- `ld_pc`  out  1  load PC from IR operand (jump).
- `ld_ac`  out  1  load accumulator from ALU output.
- `wr`  out  1  memory write strobe.
- `data_e`  out  1  drive accumulator onto data bus.
- `halt`  out  1  processor halted (sticky).
- `instr_cnt`  out  8  retired-instruction counter, wraps 255 -> 0.

## Operation
- 3-bit phase register cycles INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, then back to INST_ADDR. It advances one phase per clock.
- ALUOP group = ADD, AND, XOR, LDA.
- Strobes by phase (all other strobes 0):
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel rd`.
  - INST_LOAD: `sel rd ld_ir`.
  - IDLE: `sel rd ld_ir`.
  - OP_ADDR: `inc_pc`, and `halt` if HLT.
  - OP_FETCH: `rd` if ALUOP.
  - ALU_OP: `rd` if ALUOP; `inc_pc` if SKZ and `zero`; `ld_pc` if JMP; `data_e` if STO.
  - STORE: `rd ld_ac` if ALUOP; `ld_pc` if JMP; `wr data_e` if STO.
- HLT: in OP_ADDR the controller enters the sticky HALTED state on the next edge. In HALTED, `halt`=1, all other strobes are 0, and the phase is frozen. Only reset exits HALTED.
- SKZ with `zero`=0: no effect beyond the normal OP_ADDR increment.
- `instr_cnt` increments on the STORE -> INST_ADDR transition. It does not increment for HLT.

## Timing
- Moore outputs: all strobes are a combinational decode of the registered phase, the HALTED flag and `opcode`. Each strobe is valid for the whole phase cycle.
- One instruction takes 8 cycles. HLT reaches HALTED 5 cycles after leaving reset phase INST_ADDR.
- Reset: when `rst_n`=0 at a rising edge, phase goes to INST_ADDR, HALTED clears and `instr_cnt` goes to 0.
- While `rst_n`=0, every output is forced to 0, including `sel`.
- The first cycle after release shows INST_ADDR (`sel`=1).
- Reset asserted mid-instruction aborts it. No `wr` or `ld_ac` is issued in the cycle reset is low.
- `zero` is not sampled outside ALU_OP. `opcode` changes before IDLE are ignored.
- `instr_cnt` at 255 plus one retire gives 0, with no flag.

## Configuration
- `CPU_CTRL_STEP_EN` defined:
  - The `step` port exists.
  - After STORE the controller enters a WAIT phase (all strobes 0, `halt`=0) and holds there until it samples `step`=1. The next cycle is then INST_ADDR.
  - `step` high during any other phase is ignored.
  - HLT still dominates: HALTED is never exited by `step`.
- Undefined: no `step` port and no WAIT phase. STORE goes directly to INST_ADDR.

## Structure
- The shared CPU package (or defines file) holds:
  - `OPCODE_HLT`=000, `OPCODE_SKZ`=001, `OPCODE_ADD`=010, `OPCODE_AND`=011, `OPCODE_XOR`=100, `OPCODE_LDA`=101, `OPCODE_STO`=110, `OPCODE_JMP`=111 (same macros the ALU uses).
  - The phase encodings.
- One natural sub-module: `cpu_phase_counter`, which owns the phase register, the HALTED flag and the WAIT logic. Decode stays in `cpu_controller`.

## Test plan
- Reset behaviour: hold `rst_n`=0 for 2 cycles, then release.
  - During reset: all outputs 0.
  - Next cycle: `sel`=1, `rd`=0.
  - Following cycle: `sel`=1, `rd`=1.
- ADD: `opcode`=010 for one full cycle.
  - `rd`=1 in OP_FETCH, ALU_OP and STORE.
  - `ld_ac`=1 only in STORE; `wr`=0 throughout.
  - `instr_cnt` 0 -> 1.
- STO: `opcode`=110.
  - `data_e`=1 in ALU_OP and STORE; `wr`=1 only in STORE.
  - `rd`=0 after IDLE.
- SKZ and JMP:
  - SKZ with `zero`=1 gives `inc_pc`=1 in both OP_ADDR and ALU_OP; with `zero`=0, only in OP_ADDR.
  - JMP (111) gives `ld_pc`=1 in ALU_OP and STORE.
- HLT then reset:
  - `opcode`=000 gives `halt`=1 from OP_ADDR. It stays 1 with all strobes 0 for 20 cycles.
  - `rst_n` low for 1 cycle clears `halt`; `sel`=1 next cycle.
- With `CPU_CTRL_STEP_EN`:
  - After an ADD, the controller idles in WAIT with all strobes 0 for 10 cycles.
  - A 1-cycle `step` pulse gives INST_ADDR (`sel`=1) on the following cycle.
  - A wrap check presets 255 instructions (counter at 255); the next retire gives `instr_cnt`=0.
